// File: rtl/mux2_arb_pkg.sv
// Shared types and widths for the mux2 select arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OWN    = 2'd2
    } arb_state_e;

    // Counter widths: settle wait up to 15 cycles, hold count up to 255.
    localparam int SETTLE_W = 4;
    localparam int HOLD_W   = 8;

    // Round-robin winner: a lone requester wins outright, a tie goes to prio.
    function automatic logic pick_winner(input logic [1:0] req, input logic prio);
        if (req == 2'b11) begin
            return prio;
        end
        return req[1];
    endfunction

    // Grant vector with the bit of the given requester set.
    function automatic logic [1:0] grant_vec(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// Request/grant bundle between the two requesters and the mux2 arbiter.
// Latency: none, wires only.
// Backpressure: req is a level held for the whole ownership; gnt answers it.
// Optional: MUX2_ARB_STATS_EN adds the switch/preempt statistic counters.
interface mux2_arbiter_if;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
    logic       out_valid;
    logic       busy;
`ifdef MUX2_ARB_STATS_EN
    logic [15:0] switch_count;
    logic [7:0]  preempt_count;

    modport master (output req, input gnt, input sel, input out_valid, input busy,
                    input switch_count, input preempt_count);
    modport slave  (input req, output gnt, output sel, output out_valid, output busy,
                    output switch_count, output preempt_count);
`else
    modport master (output req, input gnt, input sel, input out_valid, input busy);
    modport slave  (input req, output gnt, output sel, output out_valid, output busy);
`endif

endinterface

// File: rtl/mux2_arbiter_settle_timer.sv
// Loadable down-counter timing the mux settle window after a select change.
// Latency: done reflects the registered count (1 cycle after load/dec).
// Backpressure: none; decrementing stops at zero.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin owner of a shared mux2: drives sel, waits for settle, then grants.
// Latency: grant 1 cycle if sel already points at the winner, SETTLE_CYCLES+1 after a switch.
// Backpressure: owner keeps gnt while req is held; rotation forced after MAX_HOLD if contended.
// Optional: MUX2_ARB_STATS_EN adds switch_count/preempt_count statistics.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_HOLD      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux2_arbiter_if.slave     bus
);

    arb_state_e          state;
    logic                sel;
    logic                prio;
    logic [1:0]          gnt;
    logic                out_valid;
    logic                busy;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                winner;
    logic                other;
    logic                own_release;
    logic                own_preempt;
    logic                idle_switch;
    logic                timer_load;
    logic                timer_dec;
    logic                settle_done;

    // Decode this cycle's transition conditions from registered state and req.
    always_comb begin
        winner      = pick_winner(bus.req, prio);
        other       = ~sel;
        own_release = (state == OWN) && !bus.req[sel];
        // Compare with >= so a late contender still forces rotation once the
        // hold counter has already saturated during an uncontested stretch.
        own_preempt = (state == OWN) && bus.req[sel] && bus.req[other] &&
                      (hold_cnt >= HOLD_W'(MAX_HOLD - 1));
        idle_switch = (state == IDLE) && (bus.req != 2'b00) && (winner != sel);
        timer_load  = idle_switch || own_preempt;
        timer_dec   = (state == SETTLE);
    end

    settle_timer #(.W(SETTLE_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
        .done     (settle_done)
    );

    // Arbitration FSM with registered sel/gnt/out_valid/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            prio      <= 1'b0;
            gnt       <= 2'b00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        busy <= 1'b1;
                        if (winner == sel) begin
                            state     <= OWN;
                            gnt       <= grant_vec(sel);
                            out_valid <= 1'b1;
                            hold_cnt  <= '0;
                        end else begin
                            state <= SETTLE;
                            sel   <= winner;
                        end
                    end
                end
                SETTLE: begin
                    if (!bus.req[sel]) begin
                        // Requester gave up before the mux settled.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (settle_done) begin
                        state     <= OWN;
                        gnt       <= grant_vec(sel);
                        out_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                OWN: begin
                    if (own_release) begin
                        // Release beats a same-cycle request from the other side.
                        state     <= IDLE;
                        gnt       <= 2'b00;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        prio      <= other;
                        hold_cnt  <= '0;
                    end else if (own_preempt) begin
                        state     <= SETTLE;
                        sel       <= other;
                        prio      <= other;
                        gnt       <= 2'b00;
                        out_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 2'b00;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel       = sel;
    assign bus.gnt       = gnt;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;

`ifdef MUX2_ARB_STATS_EN
    logic [15:0] switch_cnt;
    logic [7:0]  preempt_cnt;

    // Saturating counts of sel toggles and forced rotations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_cnt  <= '0;
            preempt_cnt <= '0;
        end else begin
            if (timer_load && (switch_cnt != 16'hFFFF)) begin
                switch_cnt <= switch_cnt + 1'b1;
            end
            if (own_preempt && (preempt_cnt != 8'hFF)) begin
                preempt_cnt <= preempt_cnt + 1'b1;
            end
        end
    end

    assign bus.switch_count  = switch_cnt;
    assign bus.preempt_count = preempt_cnt;
`endif

endmodule
